mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its data-memory port.
- Arbitrates per access with fixed data priority plus an anti-starvation override for fetch.
- Sequences the memory request/response handshake with one access outstanding.
- Flags memory-side timeouts.
- Sits between the core (imem/dmem ports, plus stall logic driven by the grants) and the SRAM/bus wrapper.

Parameters:
- STARVE_MAX, 4: consecutive data wins while fetch is waiting before fetch is forced to win; must be ≥ 1.
- TIMEOUT, 64: cycles allowed in a wait state before an error is declared; must be ≥ 2.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_req, in, 1: fetch request; held with i_addr until i_gnt.
- i_addr, in, 32: fetch byte address.
- i_gnt, out, 1: fetch request accepted this cycle.
- i_rvalid, out, 1: fetch data valid (1-cycle pulse).
- i_rdata, out, 32: fetch data.
- d_req, in, 1: data request; held with its attributes until d_gnt.
- d_addr, in, 32: data byte address.
- d_wdata, in, 32: store data.
- d_be, in, 4: byte enables.
- d_we, in, 1: 1 = write, 0 = read.
- d_gnt, out, 1: data request accepted.
- d_rvalid, out, 1: data response (read data or write ack).
- d_rdata, out, 32: load data.
- m_req, out, 1: memory request.
- m_addr, out, 32: memory address.
- m_wdata, out, 32: memory write data.
- m_be, out, 4: memory byte enables.
- m_we, out, 1: memory write enable.
- m_gnt, in, 1: memory accepted request.
- m_rvalid, in, 1: memory response.
- m_rdata, in, 32: memory read data.
- err, out, 1: timeout pulse.

Behaviour:
- Reset: async on rst_n low.
  - State goes to IDLE, starvation counter 0, timeout counter 0, err 0.
  - While rst_n = 0, m_req, i_gnt, d_gnt, i_rvalid and d_rvalid are forced to 0 (combinationally gated).
- States: IDLE, WAIT_I, WAIT_D.
- IDLE:
  - If neither request is high: m_req = 0 and all memory outputs are 0.
  - Otherwise the winner is selected combinationally:
    - I wins if i_req && (!d_req || starve_cnt == STARVE_MAX).
    - Else D wins.
  - m_req = 1, with m_addr, m_wdata, m_be and m_we driven from the winner. For fetch: m_we = 0, m_be = 4'hF, m_wdata = 0.
  - Winner's gnt = m_gnt, in the same cycle (combinational pass-through).
  - On m_gnt: go to WAIT_I or WAIT_D and clear the timeout counter. Without m_gnt, stay in IDLE and re-arbitrate next cycle; the winner may change.
- Starvation counter, updated on the grant edge only:
  - D granted while i_req = 1: increment, saturating at STARVE_MAX.
  - I granted: clear to 0.
  - D granted with i_req = 0: clear to 0.
- WAIT_x:
  - m_req = 0; gnts are 0.
  - On m_rvalid: x_rvalid = 1 and x_rdata = m_rdata combinationally in that cycle, then return to IDLE.
  - Writes also complete on m_rvalid (d_rvalid serves as write ack; d_rdata then undefined, drive m_rdata).
  - A new request cannot issue in the same cycle as a response. Minimum two cycles per access (grant cycle + response cycle at zero memory latency).
- Timeout:
  - The counter increments each cycle in WAIT_x without m_rvalid.
  - When it reaches TIMEOUT-1 without m_rvalid: in that cycle assert err = 1, x_rvalid = 1 and x_rdata = ERR_DATA, then go to IDLE.
  - m_rvalid arriving in the same cycle as expiry takes precedence (normal response, err = 0).
- m_rvalid in IDLE (late or stale response, e.g. after reset or timeout) is ignored; no rvalid pulse is produced.
- i_rdata and d_rdata are 0 whenever the matching rvalid is 0.
- Simultaneous i_req and d_req with counter below max: D wins. When the counter equals max: I wins, then the counter resets.

Test Plan:
- Single fetch, zero-latency memory:
  - Stimulus: i_req with i_addr = 0x100; m_gnt in the same cycle; m_rvalid the next cycle with m_rdata = 0x00500093.
  - Required: i_gnt in cycle 0, i_rvalid with i_rdata = 0x00500093 in cycle 1, m_be = 0xF, m_we = 0.
- Priority:
  - Stimulus: i_req and d_req held high simultaneously; D is a store to addr 0x200, wdata 0xA5A5A5A5, be 0x3.
  - Required: D is granted first with m_we = 1, m_be = 0x3; d_rvalid ack follows; then I is granted.
- Starvation (STARVE_MAX = 4):
  - Stimulus: i_req held high while d_req is continuously high for 10 accesses.
  - Required: grant order is D,D,D,D,I,D,D,D,D,I.
- Stalling memory:
  - Stimulus: d_req read; m_gnt withheld for 3 cycles, then given; m_rvalid 5 cycles later with 0x12345678.
  - Required: d_gnt only in the m_gnt cycle, d_addr stable throughout; d_rvalid with 0x12345678; err = 0.
- Timeout (TIMEOUT = 64):
  - Stimulus: a granted fetch; m_rvalid never arrives.
  - Required: exactly 64 cycles after the grant, err pulses for 1 cycle with i_rvalid and i_rdata = 0xDEADBEEF, and the state returns to IDLE.
  - Follow-up: a late m_rvalid then produces no rvalid pulse.
- Reset mid-access:
  - Stimulus: rst_n is pulled low while in WAIT_D.
  - Required: m_req and gnts drop immediately; after release, m_rvalid is ignored, the starvation counter is 0, and the next simultaneous request goes to D.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports, one access outstanding.
// Latency: grant is combinational with m_gnt; response is forwarded combinationally in the m_rvalid cycle.
// Backpressure: requesters hold until their gnt; a withheld m_gnt simply re-arbitrates in the next cycle.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    input  logic        d_we,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    output logic        m_we,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        err
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic [TW-1:0]   to_cnt, to_nxt;
    logic            i_win;
    logic            expired;
    logic [31:0]     rsp_data;
    logic            m_req_c, i_gnt_c, d_gnt_c, i_rvalid_c, d_rvalid_c;

    // Fetch wins only when data is idle or fetch has waited out STARVE_MAX data wins in a row.
    assign i_win   = i_req && (!d_req || (starve_cnt == SW'(STARVE_MAX)));
    assign expired = (to_cnt == TW'(TIMEOUT - 1));
    // A real response in the expiry cycle beats the timeout.
    assign rsp_data = m_rvalid ? m_rdata : ERR_DATA;

    // Handshake-visible outputs are held low for the whole time reset is asserted.
    assign m_req    = m_req_c    & rst_n;
    assign i_gnt    = i_gnt_c    & rst_n;
    assign d_gnt    = d_gnt_c    & rst_n;
    assign i_rvalid = i_rvalid_c & rst_n;
    assign d_rvalid = d_rvalid_c & rst_n;

    // State, starvation and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            to_cnt     <= to_nxt;
        end
    end

    // Arbitration, memory request muxing and response/timeout routing.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        to_nxt     = to_cnt;
        m_req_c    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_be       = '0;
        m_we       = 1'b0;
        i_gnt_c    = 1'b0;
        d_gnt_c    = 1'b0;
        i_rvalid_c = 1'b0;
        d_rvalid_c = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    m_req_c = 1'b1;
                    if (i_win) begin
                        m_addr  = i_addr;
                        m_be    = 4'hF;
                        i_gnt_c = m_gnt;
                    end else begin
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        m_be    = d_be;
                        m_we    = d_we;
                        d_gnt_c = m_gnt;
                    end
                    if (m_gnt) begin
                        state_nxt = i_win ? WAIT_I : WAIT_D;
                        to_nxt    = '0;
                        // Only a data win over a waiting fetch counts towards starvation.
                        if (i_win || !i_req) begin
                            starve_nxt = '0;
                        end else if (starve_cnt != SW'(STARVE_MAX)) begin
                            starve_nxt = starve_cnt + 1'b1;
                        end
                    end
                end
            end
            WAIT_I, WAIT_D: begin
                if (m_rvalid || expired) begin
                    state_nxt = IDLE;
                    err       = !m_rvalid;
                    if (state == WAIT_I) begin
                        i_rvalid_c = 1'b1;
                        i_rdata    = rsp_data;
                    end else begin
                        d_rvalid_c = 1'b1;
                        d_rdata    = rsp_data;
                    end
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a transaction-level reference model.
// The model predicts winners from pending requests and grant history, responses from a word memory.
// A separate monitor pops expected responses whenever the DUT presents an rvalid.
module tb_mem_arbiter;
    localparam int          SMAX = 4;
    localparam int          TMO  = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        m_req, m_we, m_gnt, m_rvalid, err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_we(d_we),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_we(m_we),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] ref_mem[256];
    logic [31:0] sim_mem[256];

    // reference model state
    bit          busy;
    int          since, resp_lat, starve, grant_cnt;
    // memory responder capture
    bit          cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    // agent / environment knobs
    bit          i_granted, d_granted, stray_rv;
    int          i_rate, d_rate, gnt_rate, gnt_block, lat_min, lat_max;
    bit          glog[$];
    bit          want[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Model step at the negedge: predict the arbitration outcome and queue the expected response.
    task automatic observe();
        bit   iw;
        int   idx;
        exp_t e;
        if (!rst_n) begin
            chk("rst_mreq", m_req, 0);
            chk("rst_gnts", {i_gnt, d_gnt}, 0);
            chk("rst_rvalids", {i_rvalid, d_rvalid}, 0);
            busy   = 0;
            starve = 0;
            exp_q.delete();
        end else begin
            if (i_gnt) glog.push_back(1'b0);
            if (d_gnt) glog.push_back(1'b1);
            if (!busy) begin
                if (m_rvalid) chk("stale_rvalid", {i_rvalid, d_rvalid}, 0);
                if (i_req || d_req) begin
                    iw = i_req && (!d_req || starve == SMAX);
                    chk("m_req", m_req, 1);
                    chk("m_addr", m_addr, iw ? i_addr : d_addr);
                    chk("m_we", m_we, iw ? 1'b0 : d_we);
                    chk("m_be", m_be, iw ? 4'hF : d_be);
                    chk("m_wdata", m_wdata, iw ? 32'd0 : d_wdata);
                    chk("i_gnt", i_gnt, iw && m_gnt);
                    chk("d_gnt", d_gnt, !iw && m_gnt);
                    if (m_gnt) begin
                        grant_cnt++;
                        if (iw || !i_req) starve = 0;
                        else if (starve < SMAX) starve++;
                        resp_lat   = $urandom_range(lat_max, lat_min);
                        idx        = iw ? int'(i_addr[9:2]) : int'(d_addr[9:2]);
                        e.is_d     = !iw;
                        e.err      = resp_lat > TMO;
                        e.cyc      = cyc + (e.err ? TMO : resp_lat);
                        e.chk_data = iw || !d_we || e.err;
                        e.data     = e.err ? ERRD : ref_mem[idx];
                        if (!iw && d_we) ref_mem[idx] = merge(ref_mem[idx], d_wdata, d_be);
                        exp_q.push_back(e);
                        busy      = 1;
                        since     = 0;
                        cap_we    = m_we;
                        cap_addr  = m_addr;
                        cap_wdata = m_wdata;
                        cap_be    = m_be;
                        if (iw) i_granted = 1;
                        else    d_granted = 1;
                    end
                end else begin
                    chk("idle_mreq", m_req, 0);
                    chk("idle_gnts", {i_gnt, d_gnt}, 0);
                    chk("idle_maddr", m_addr, 0);
                    chk("idle_mwdata", m_wdata, 0);
                    chk("idle_mbe_we", {m_be, m_we}, 0);
                end
            end else begin
                since++;
                chk("wait_mreq", m_req, 0);
                chk("wait_gnts", {i_gnt, d_gnt}, 0);
                if (since == resp_lat || since == TMO) busy = 0;
            end
        end
    endtask

    // Drive the next cycle's inputs: requesters, memory grant and memory responder.
    task automatic drive();
        if (rst_n) begin
            if (i_granted) begin i_req = 0; i_granted = 0; end
            if (d_granted) begin d_req = 0; d_granted = 0; end
            if (!i_req && $urandom_range(99) < i_rate) begin
                i_req  = 1;
                i_addr = {22'd0, 8'($urandom), 2'b00};
            end
            if (!d_req && $urandom_range(99) < d_rate) begin
                d_req   = 1;
                d_addr  = {22'd0, 8'($urandom), 2'b00};
                d_we    = 1'($urandom);
                d_be    = 4'($urandom_range(15, 1));
                d_wdata = $urandom;
            end
        end
        if (gnt_block > 0) begin
            m_gnt = 0;
            gnt_block--;
        end else begin
            m_gnt = ($urandom_range(99) < gnt_rate);
        end
        m_rdata  = $urandom;
        m_rvalid = 0;
        if (busy && since + 1 == resp_lat) begin
            m_rvalid = 1;
            if (cap_we) sim_mem[cap_addr[9:2]] = merge(sim_mem[cap_addr[9:2]], cap_wdata, cap_be);
            else        m_rdata = sim_mem[cap_addr[9:2]];
        end else if (stray_rv) begin
            m_rvalid = 1;
            stray_rv = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_quiet(int budget);
        int n = 0;
        while ((i_req || d_req || busy || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("quiet_within_budget", n < budget, 1);
    endtask

    task automatic run_grants(int cnt, int budget);
        int n  = 0;
        int g0 = grant_cnt;
        while (grant_cnt < g0 + cnt && n < budget) begin
            step();
            n++;
        end
        chk("grants_within_budget", n < budget, 1);
    endtask

    // Monitor: every response the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (i_rvalid || d_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", {i_rvalid, d_rvalid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rv_side", {i_rvalid, d_rvalid}, e.is_d ? 2'b01 : 2'b10);
                    chk("rv_cycle", cyc, e.cyc);
                    chk("rv_err", err, e.err);
                    if (e.chk_data) chk("rv_data", e.is_d ? d_rdata : i_rdata, e.data);
                    chk("rv_other_rdata", e.is_d ? i_rdata : d_rdata, 0);
                end
            end else begin
                chk("no_rv_err", err, 0);
                chk("no_rv_rdata", i_rdata | d_rdata, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            sim_mem[i] = v;
        end
        ref_mem[64]  = 32'h0050_0093; sim_mem[64]  = 32'h0050_0093;
        ref_mem[192] = 32'h1234_5678; sim_mem[192] = 32'h1234_5678;

        // Reset with everything active on the inputs: outputs must stay quiet.
        rst_n = 0; i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200;
        d_wdata = 0; d_be = 4'hF; d_we = 0; m_gnt = 1; m_rvalid = 1; m_rdata = 32'h5555_AAAA;
        i_rate = 0; d_rate = 0; gnt_rate = 100; gnt_block = 0; lat_min = 1; lat_max = 1;
        busy = 0; since = 0; resp_lat = 0; starve = 0; grant_cnt = 0;
        i_granted = 0; d_granted = 0; stray_rv = 0;
        #1;
        chk("async_rst_mreq", m_req, 0);
        chk("async_rst_gnts", {i_gnt, d_gnt}, 0);
        repeat (3) step();
        rst_n = 1; i_req = 0; d_req = 0;
        step();

        // Single fetch against a zero-latency memory.
        i_req = 1; i_addr = 32'h100; m_gnt = 1;
        wait_quiet(20);

        // Priority: a store and a fetch raised together; data goes first.
        glog.delete();
        i_req = 1; i_addr = 32'h104;
        d_req = 1; d_addr = 32'h200; d_wdata = 32'hA5A5_A5A5; d_be = 4'h3; d_we = 1;
        wait_quiet(30);
        chk("prio_first_is_d", glog.size() > 0 ? int'(glog[0]) : 2, 1);
        chk("prio_then_i", glog.size() > 1 ? int'(glog[1]) : 2, 0);
        // Read back the partially written word.
        d_req = 1; d_addr = 32'h200; d_we = 0; d_be = 4'hF;
        wait_quiet(30);

        // Starvation: both ports continuously busy for ten accesses.
        glog.delete();
        i_rate = 100; d_rate = 100;
        run_grants(10, 200);
        i_rate = 0; d_rate = 0;
        wait_quiet(50);
        for (int k = 0; k < 10; k++) chk("starve_order", k < glog.size() ? int'(glog[k]) : 2, want[k]);

        // Stalling memory: grant withheld three cycles, response five cycles later.
        d_req = 1; d_addr = 32'h300; d_we = 0; d_be = 4'hF;
        m_gnt = 0; gnt_block = 2; lat_min = 5; lat_max = 5;
        wait_quiet(30);

        // Response arriving exactly at expiry wins over the timeout.
        lat_min = TMO; lat_max = TMO;
        i_req = 1; i_addr = 32'h3F0;
        wait_quiet(100);

        // Timeout: no response at all, then a late stray response.
        lat_min = 1000; lat_max = 1000;
        i_req = 1; i_addr = 32'h010;
        wait_quiet(100);
        stray_rv = 1;
        step();
        step();

        // Randomised traffic.
        lat_min = 1; lat_max = 4; gnt_rate = 70; i_rate = 30; d_rate = 30;
        repeat (1500) step();
        i_rate = 0; d_rate = 0;
        wait_quiet(100);

        // Reset in the middle of a data access after three straight data wins.
        gnt_rate = 100; lat_min = 6; lat_max = 6; i_rate = 100; d_rate = 100;
        begin
            int n = 0;
            while (!(busy && starve == 3) && n < 300) begin
                step();
                n++;
            end
            chk("reach_wait_d_bound", n < 300, 1);
        end
        rst_n = 0;
        i_rate = 0; d_rate = 0;
        #1;
        chk("midrst_mreq", m_req, 0);
        chk("midrst_gnts", {i_gnt, d_gnt}, 0);
        step();
        step();
        rst_n = 1; i_req = 0; d_req = 0; i_granted = 0; d_granted = 0; m_rvalid = 1;
        step();
        lat_min = 1; lat_max = 1;
        glog.delete();
        i_rate = 100; d_rate = 100;
        run_grants(5, 100);
        i_rate = 0; d_rate = 0;
        wait_quiet(50);
        for (int k = 0; k < 5; k++) chk("post_rst_order", k < glog.size() ? int'(glog[k]) : 2, want[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
